bf16_stream_accumulator: RTL

- Sequential front-end that feeds the combinational hp_add adder/subtractor and consumes its result.
- Accepts a packetised stream of bfloat16 operands over a valid/ready handshake and folds each one into a running accumulator, one element per cycle.
- Presents the packet total, with class flags and sticky exceptions, on an output valid/ready handshake.
- Sits between an operand source (register file/DMA) and the FPU result writeback.

---
 rtl/bf16_stream_accumulator_pkg.sv | 32 +++
 rtl/bf16_stream_accumulator_if.sv | 30 +++
 rtl/bf16_stream_accumulator_hp_add.sv | 139 +++++++++++++
 rtl/bf16_stream_accumulator.sv | 94 +++++++++
 4 files changed

// File: rtl/bf16_stream_accumulator_pkg.sv
// Shared constants and types for the bfloat16 stream accumulator and its adder.
package fpu_pkg;

    // bfloat16 field widths
    localparam int BF16_NEXP = 8;
    localparam int BF16_NSIG = 7;
    localparam int BF16_W    = BF16_NEXP + BF16_NSIG + 1;

    // One-hot class flag bit positions
    localparam int FLAG_NORMAL    = 0;
    localparam int FLAG_SUBNORMAL = 1;
    localparam int FLAG_ZERO      = 2;
    localparam int FLAG_INF       = 3;
    localparam int FLAG_QNAN      = 4;
    localparam int FLAG_SNAN      = 5;

    // Exception vector bit positions
    localparam int EXC_INEXACT   = 0;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_DIVZERO   = 3;
    localparam int EXC_INVALID   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    localparam logic [BF16_W-1:0] BF16_POS_ZERO = '0;

endpackage

// File: rtl/bf16_stream_accumulator_if.sv
// Operand-in and result-out handshakes of the stream accumulator.
interface bf16_stream_accumulator_if #(
    parameter int NEXP = 8,
    parameter int NSIG = 7,
    parameter int CNTW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NEXP+NSIG:0]   in_data;
    logic                 in_sub;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [NEXP+NSIG:0]   out_data;
    logic [5:0]           out_flags;
    logic [4:0]           out_exc;
    logic [CNTW-1:0]      out_count;

    // Operand source / result consumer side
    modport master (
        output in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_flags, out_exc, out_count
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_flags, out_exc, out_count
    );
endinterface

// File: rtl/bf16_stream_accumulator_hp_add.sv
// Combinational bfloat16 adder/subtractor, round-to-nearest-even, with
// subnormal support, IEEE-style exception vector and one-hot result class.
module hp_add
    import fpu_pkg::*;
#(
    parameter int NEXP = BF16_NEXP,
    parameter int NSIG = BF16_NSIG
) (
    input  logic [NEXP+NSIG:0] a,
    input  logic [NEXP+NSIG:0] b,
    input  logic               operation,
    output logic [NEXP+NSIG:0] s,
    output logic [4:0]         exception,
    output logic [5:0]         bfFlags
);
    // hidden bit + stored significand + guard/round/sticky
    localparam int MW   = NSIG + 4;
    localparam int EMAX = (1 << NEXP) - 1;

    logic            w_sa, w_sb;
    logic [NEXP-1:0] w_ea, w_eb;
    logic [NSIG-1:0] w_fa, w_fb;
    logic            w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;

    assign w_sa     = a[NEXP+NSIG];
    assign w_sb     = b[NEXP+NSIG] ^ operation;
    assign w_ea     = a[NEXP+NSIG-1:NSIG];
    assign w_eb     = b[NEXP+NSIG-1:NSIG];
    assign w_fa     = a[NSIG-1:0];
    assign w_fb     = b[NSIG-1:0];
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[NSIG-1];
    assign w_b_snan = w_b_nan && !w_fb[NSIG-1];

    logic               w_swap, w_s_big, w_s_sml, w_sticky, w_inexact, w_round_up;
    logic [MW-1:0]      w_m_big, w_m_sml, w_m_shift, w_norm;
    logic [MW:0]        w_sum;
    logic [NSIG+1:0]    w_rnd;
    logic [NSIG-1:0]    w_frac;
    logic [NEXP+NSIG:0] w_res;
    logic [4:0]         w_exc;
    int                 w_e_big, w_e_sml, w_diff, w_lead, w_sh, w_e_res;

    // Align, add/subtract magnitudes, normalise, round, then override for specials
    always_comb begin
        w_swap  = {w_eb, w_fb} > {w_ea, w_fa};
        w_s_big = w_swap ? w_sb : w_sa;
        w_s_sml = w_swap ? w_sa : w_sb;
        w_e_big = w_swap ? ((w_eb == '0) ? 1 : int'(w_eb)) : ((w_ea == '0) ? 1 : int'(w_ea));
        w_e_sml = w_swap ? ((w_ea == '0) ? 1 : int'(w_ea)) : ((w_eb == '0) ? 1 : int'(w_eb));
        w_m_big = w_swap ? {|w_eb, w_fb, 3'b000} : {|w_ea, w_fa, 3'b000};
        w_m_sml = w_swap ? {|w_ea, w_fa, 3'b000} : {|w_eb, w_fb, 3'b000};
        w_diff  = w_e_big - w_e_sml;

        // Bits shifted past the sticky position are OR-ed into it
        w_m_shift = w_m_sml >> w_diff;
        w_sticky  = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if ((i < w_diff) && w_m_sml[i]) w_sticky = 1'b1;
        end
        w_m_shift[0] = w_m_shift[0] | w_sticky;

        if (w_s_big == w_s_sml) w_sum = {1'b0, w_m_big} + {1'b0, w_m_shift};
        else                    w_sum = {1'b0, w_m_big} - {1'b0, w_m_shift};

        w_lead = -1;
        for (int i = 0; i < MW; i++) begin
            if (w_sum[i]) w_lead = i;
        end

        // Left shift is clamped so the exponent never drops below the subnormal floor
        w_sh = 0;
        if (w_sum[MW]) begin
            w_norm    = w_sum[MW:1];
            w_norm[0] = w_norm[0] | w_sum[0];
            w_e_res   = w_e_big + 1;
        end else begin
            w_sh = (MW - 1) - w_lead;
            if (w_sh > w_e_big - 1) w_sh = w_e_big - 1;
            w_norm  = w_sum[MW-1:0] << w_sh;
            w_e_res = w_e_big - w_sh;
        end

        w_inexact  = |w_norm[2:0];
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd      = {1'b0, w_norm[MW-1:3]} + {{(NSIG+1){1'b0}}, w_round_up};
        if (w_rnd[NSIG+1]) begin
            w_e_res = w_e_res + 1;
            w_frac  = '0;
        end else begin
            w_frac = w_rnd[NSIG-1:0];
            if (!w_rnd[NSIG]) w_e_res = 0;
        end

        w_exc = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_res = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            w_exc[EXC_INVALID] = w_a_snan | w_b_snan | (w_a_inf & w_b_inf & (w_sa != w_sb));
        end else if (w_a_inf) begin
            w_res = {w_sa, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (w_b_inf) begin
            w_res = {w_sb, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (w_sum == '0) begin
            // Exact zero: -0 only when both operands are -0
            w_res = {w_sa & w_sb, {(NEXP+NSIG){1'b0}}};
        end else if (w_e_res >= EMAX) begin
            w_res = {w_s_big, {NEXP{1'b1}}, {NSIG{1'b0}}};
            w_exc[EXC_OVERFLOW] = 1'b1;
            w_exc[EXC_INEXACT]  = 1'b1;
        end else begin
            w_res = {w_s_big, NEXP'(w_e_res), w_frac};
            w_exc[EXC_INEXACT]   = w_inexact;
            w_exc[EXC_UNDERFLOW] = w_inexact && (w_e_res == 0);
        end
        w_exc[EXC_DIVZERO] = 1'b0;
    end

    // One-hot classification of the result
    always_comb begin
        bfFlags = '0;
        if (w_res[NEXP+NSIG-1:NSIG] == '1) begin
            if (w_res[NSIG-1:0] == '0)  bfFlags[FLAG_INF]  = 1'b1;
            else if (w_res[NSIG-1])     bfFlags[FLAG_QNAN] = 1'b1;
            else                        bfFlags[FLAG_SNAN] = 1'b1;
        end else if (w_res[NEXP+NSIG-1:NSIG] == '0) begin
            if (w_res[NSIG-1:0] == '0)  bfFlags[FLAG_ZERO]      = 1'b1;
            else                        bfFlags[FLAG_SUBNORMAL] = 1'b1;
        end else begin
            bfFlags[FLAG_NORMAL] = 1'b1;
        end
    end

    assign s         = w_res;
    assign exception = w_exc;

endmodule

// File: rtl/bf16_stream_accumulator.sv
// Folds a packetised bfloat16 operand stream into a running sum and presents
// the packet total with class flags, sticky exceptions and element count.
module bf16_stream_accumulator
    import fpu_pkg::*;
#(
    parameter int NEXP = BF16_NEXP,
    parameter int NSIG = BF16_NSIG,
    parameter int CNTW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    bf16_stream_accumulator_if.slave bus
);
    localparam int              W          = NEXP + NSIG + 1;
    localparam logic [5:0]      FLAGS_ZERO = 6'b1 << FLAG_ZERO;

    acc_state_t      r_state;
    logic [W-1:0]    r_acc;
    logic [4:0]      r_exc;
    logic [CNTW-1:0] r_count;
    logic [5:0]      r_flags;
    logic            r_out_valid;

    logic [W-1:0]    w_sum;
    logic [4:0]      w_exc;
    logic [5:0]      w_flags;
    logic            w_xfer_in;

    assign bus.in_ready = (r_state != HOLD);
    assign w_xfer_in    = bus.in_valid && (r_state != HOLD);

    hp_add #(
        .NEXP (NEXP),
        .NSIG (NSIG)
    ) u_hp_add (
        .a         (r_acc),
        .b         (bus.in_data),
        .operation (bus.in_sub),
        .s         (w_sum),
        .exception (w_exc),
        .bfFlags   (w_flags)
    );

    // The result registers double as the output registers
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_acc;
    assign bus.out_flags = r_flags;
    assign bus.out_exc   = r_exc;
    assign bus.out_count = r_count;

    // Packet FSM: accumulate on each accepted operand, hold the total until drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= W'(BF16_POS_ZERO);
            r_exc       <= '0;
            r_count     <= '0;
            r_flags     <= FLAGS_ZERO;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, ACC: begin
                    if (w_xfer_in) begin
                        r_acc   <= w_sum;
                        r_exc   <= r_exc | w_exc;
                        r_count <= (&r_count) ? r_count : r_count + CNTW'(1);
                        r_flags <= w_flags;
                        if (bus.in_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= W'(BF16_POS_ZERO);
                        r_exc       <= '0;
                        r_count     <= '0;
                        r_flags     <= FLAGS_ZERO;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
